// File: rtl/sudoku_ctrl.sv
// sudoku_ctrl: loads an 81-cell puzzle from a valid/ready stream, launches an
// external solver, waits for it with a cycle timeout, then streams the grid
// back out in row-major order together with a completion status.
module sudoku_ctrl #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         abort,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_data,
  output logic         out_last,
  output logic         solver_start,
  output logic [323:0] solver_grid,
  input  logic         solver_done,
  input  logic [323:0] solver_result,
  output logic         busy,
  output logic [1:0]   status
);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, UNLOAD} state_t;

  localparam logic [6:0]  LAST_IDX     = 7'd80;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_NONE    = 2'd0;
  localparam logic [1:0] ST_SOLVED  = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_BAD     = 2'd3;

  state_t        state_reg, state_next;
  logic [6:0]    idx_reg, idx_next;
  logic [15:0]   cnt_reg, cnt_next;
  logic          bad_reg, bad_next;
  logic [1:0]    status_reg, status_next;
  logic [323:0]  grid_reg;
  logic [3:0]    cell_w [81];

  logic          in_fire;
  logic          out_fire;
  logic          load_we;
  logic          result_we;
  logic          in_bad;
  logic [3:0]    load_digit;

  // Digits above 9 are not legal Sudoku values: store them as empty.
  assign in_bad     = (in_data > 4'd9);
  assign load_digit = in_bad ? 4'd0 : in_data;

  // Per-cell view of the packed grid, used by the output read mux.
  generate
    for (genvar gi = 0; gi < 81; gi++) begin : g_cell
      assign cell_w[gi] = grid_reg[gi*4 +: 4];
    end
  endgenerate

  assign solver_grid = grid_reg;
  assign status      = status_reg;

  // Next-state, datapath control and Moore outputs; abort overrides everything.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    cnt_next     = cnt_reg;
    bad_next     = bad_reg;
    status_next  = status_reg;
    load_we      = 1'b0;
    result_we    = 1'b0;

    in_ready     = (state_reg == IDLE) || (state_reg == LOAD);
    out_valid    = (state_reg == UNLOAD);
    out_data     = cell_w[idx_reg];
    out_last     = (idx_reg == LAST_IDX);
    solver_start = (state_reg == START);
    busy         = (state_reg != IDLE);

    // A handshake coinciding with abort is not taken.
    in_fire      = in_valid && in_ready && !abort;
    out_fire     = out_valid && out_ready && !abort;

    case (state_reg)
      IDLE: begin
        if (in_fire) begin
          load_we     = 1'b1;
          idx_next    = 7'd1;
          status_next = ST_NONE;
          bad_next    = in_bad;
          state_next  = LOAD;
        end
      end
      LOAD: begin
        if (in_fire) begin
          load_we  = 1'b1;
          bad_next = bad_reg | in_bad;
          if (idx_reg == LAST_IDX) begin
            idx_next = 7'd0;
            // A bad digit anywhere (including this last beat) skips the solver.
            if (bad_reg || in_bad) begin
              status_next = ST_BAD;
              state_next  = UNLOAD;
            end else begin
              state_next  = START;
            end
          end else begin
            idx_next = idx_reg + 7'd1;
          end
        end
      end
      START: begin
        cnt_next   = 16'd0;
        state_next = WAIT;
      end
      WAIT: begin
        cnt_next = cnt_reg + 16'd1;
        // solver_done is checked first so it wins over a same-cycle timeout.
        if (solver_done) begin
          result_we   = 1'b1;
          status_next = ST_SOLVED;
          state_next  = UNLOAD;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          status_next = ST_TIMEOUT;
          state_next  = UNLOAD;
        end
      end
      UNLOAD: begin
        if (out_fire) begin
          if (idx_reg == LAST_IDX) begin
            idx_next   = 7'd0;
            bad_next   = 1'b0;
            state_next = IDLE;
          end else begin
            idx_next = idx_reg + 7'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (abort) begin
      state_next  = IDLE;
      idx_next    = 7'd0;
      cnt_next    = 16'd0;
      bad_next    = 1'b0;
      status_next = ST_NONE;
      load_we     = 1'b0;
      result_we   = 1'b0;
    end
  end

  // State and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      idx_reg    <= 7'd0;
      cnt_reg    <= 16'd0;
      bad_reg    <= 1'b0;
      status_reg <= ST_NONE;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      cnt_reg    <= cnt_next;
      bad_reg    <= bad_next;
      status_reg <= status_next;
    end
  end

  // Grid storage: whole-grid overwrite from the solver, or one cell per load beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grid_reg <= '0;
    end else if (result_we) begin
      grid_reg <= solver_result;
    end else if (load_we) begin
      grid_reg[{idx_reg, 2'b00} +: 4] <= load_digit;
    end
  end

endmodule

// File: doc/sudoku_ctrl.md
SUDOKU_CTRL -- requirements
Module: sudoku_ctrl

Parameters
REQ-001 SHALL provide TIMEOUT_CYCLES, default 4096, range 1..65535: maximum solver cycles allowed before abandoning.

Interface
REQ-002 SHALL have clk, input, 1, the single clock; all logic rises on posedge clk.
REQ-003 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have abort, input, 1, synchronous soft clear.
REQ-005 SHALL have in_valid / in_ready / in_data, input / output / input, 1 / 1 / 4: cell stream in row-major order, digit 0 meaning empty.
REQ-006 SHALL have out_valid / out_ready / out_data / out_last, output / input / output / output, 1 / 1 / 4 / 1: result stream in row-major order.
REQ-007 SHALL have solver_start, output, 1: one-cycle pulse launching the solver.
REQ-008 SHALL have solver_grid, output, 324: loaded grid, cell (r,c) at bits [(r*9+c)*4 +: 4].
REQ-009 SHALL have solver_done / solver_result, input / input, 1 / 324: solver completion and its grid, same packing as solver_grid.
REQ-010 SHALL have busy, output, 1, and status, output, 2: 0 none, 1 solved, 2 timeout, 3 bad input.

Function
REQ-011 SHALL implement states IDLE, LOAD, START, WAIT, UNLOAD.
REQ-012 SHALL drive in_ready=1 only in IDLE and LOAD, and out_valid=1 only in UNLOAD.
REQ-013 SHALL write in_data to cell idx and increment the 7-bit idx on each in_valid&in_ready beat.
REQ-014 SHALL move from IDLE to LOAD on the first accepted beat, set idx to 1, and clear status to 0 on that same edge.
REQ-015 SHALL store any in_data > 9 as 0 and set a sticky bad_digit flag.
REQ-016 SHALL, on the 81st accepted beat (idx==80), reset idx to 0 and go to START; if bad_digit is set it SHALL go to UNLOAD with status=3 instead.
REQ-017 SHALL assert solver_start for exactly the one cycle spent in START, clear the wait counter, then go to WAIT.
REQ-018 SHALL, in WAIT, increment the 16-bit wait counter every cycle.
REQ-019 SHALL, in WAIT, on solver_done=1 copy solver_result into the grid, set status=1 and go to UNLOAD.
REQ-020 SHALL, in WAIT, when the counter reaches TIMEOUT_CYCLES-1 without solver_done, leave the grid unchanged, set status=2 and go to UNLOAD.
REQ-021 SHALL give solver_done priority when solver_done and timeout coincide.
REQ-022 SHALL ignore solver_done outside WAIT.
REQ-023 SHALL, in UNLOAD, drive out_data=grid[idx] and out_last=(idx==80), holding both stable while out_ready=0.
REQ-024 SHALL advance idx on each out_valid&out_ready and, on the beat with out_last, return to IDLE with idx=0.
REQ-025 SHALL hold status from the end of WAIT/LOAD until the first accepted beat of the next load.
REQ-026 SHALL drive busy=1 in every state except IDLE.
REQ-027 SHALL drive solver_grid continuously from the grid registers.
REQ-028 SHALL, on abort=1 in any state, go to IDLE next cycle, clear idx, the counter, bad_digit and status, and accept no handshake in that cycle; the grid contents are don't-care.
REQ-029 SHALL, when abort and an in/out handshake coincide, let abort win.

Reset
REQ-030 SHALL, while rst=1, force state=IDLE, idx=0, counter=0, bad_digit=0, status=0, grid all 0.
REQ-031 SHALL drive in_ready=1, out_valid=0, solver_start=0, busy=0 during and immediately after reset.
REQ-032 SHALL discard any load or unload in progress when rst asserts mid-operation; no partial output resumes.

Verification
REQ-033 Bench SHALL cover: 81 valid digits, solver_done asserted 10 cycles after start with a solved grid -> exactly one solver_start pulse; status=1; 81 out beats matching solver_result; out_last only on beat 81.
REQ-034 Bench SHALL cover: digit 12 at cell 5 -> solver_start never asserted; status=3; out beat 6 = 0; other cells echo input.
REQ-035 Bench SHALL cover: TIMEOUT_CYCLES=8 with the solver silent -> UNLOAD entered 8 cycles after START; status=2; output equals the loaded grid.
REQ-036 Bench SHALL cover: solver_done on the timeout cycle -> status=1 and output equals solver_result.
REQ-037 Bench SHALL cover: random out_ready (50%) and in_valid gaps -> no lost or duplicated cells; out_data stable while stalled.
REQ-038 Bench SHALL cover: abort at load beat 40, and separately rst during WAIT -> IDLE next cycle (immediately for rst), busy=0, status=0, and the next full puzzle processes correctly.
